// File: rtl/mem_port_arbiter_if.sv
// Bundle of all handshake/bus signals around mem_port_arbiter: the fetch
// requester (imem_*), the data requester (dmem_*) and the shared downstream
// memory port (mem_*). The arbiter takes the slave view. The pipeline plus
// the memory model take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    // Instruction-fetch requester
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [MASK_WIDTH-1:0] imem_rmask;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  imem_resp;

    // Data requester
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [MASK_WIDTH-1:0] dmem_rmask;
    logic [MASK_WIDTH-1:0] dmem_wmask;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [DATA_WIDTH-1:0] dmem_rdata;
    logic                  dmem_resp;

    // Shared downstream memory port
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MASK_WIDTH-1:0] mem_rmask;
    logic [MASK_WIDTH-1:0] mem_wmask;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  imem_addr, imem_rmask,
        output imem_rdata, imem_resp,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp,
        output mem_addr, mem_rmask, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output imem_addr, imem_rmask,
        input  imem_rdata, imem_resp,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the fetch (imem) and
// data (dmem) requesters. Each port latches its single-cycle request pulse
// into a one-entry pending buffer. An IDLE cycle issues the granted buffer
// downstream for exactly one cycle. The FSM then waits for mem_resp and
// routes it to the owner in that same cycle. On a tie, the port that was not
// served last is granted, so the first tie after reset goes to dmem.
// Optional feature macro: MEM_ARB_PERF_EN adds saturating grant/conflict
// counters (perf_imem_grants, perf_dmem_grants, perf_conflict_cycles).
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PERF_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    mem_port_arbiter_if.slave         bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] perf_imem_grants,
    output logic [PERF_CNT_WIDTH-1:0] perf_dmem_grants,
    output logic [PERF_CNT_WIDTH-1:0] perf_conflict_cycles
`endif
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int PORTS      = 2;   // index 0 = imem, 1 = dmem

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    state_t state_reg;
    logic   last_grant_d_reg;        // 0: imem served last, 1: dmem served last

    // Per-port request view. imem has no write side, so it is tied off.
    logic [ADDR_WIDTH-1:0] in_addr  [PORTS];
    logic [MASK_WIDTH-1:0] in_rmask [PORTS];
    logic [MASK_WIDTH-1:0] in_wmask [PORTS];
    logic [DATA_WIDTH-1:0] in_wdata [PORTS];

    logic [PORTS-1:0]      req;
    logic [PORTS-1:0]      clear;
    logic [PORTS-1:0]      accept;
    logic [PORTS-1:0]      buf_valid;
    logic [ADDR_WIDTH-1:0] buf_addr  [PORTS];
    logic [MASK_WIDTH-1:0] buf_rmask [PORTS];
    logic [MASK_WIDTH-1:0] buf_wmask [PORTS];
    logic [DATA_WIDTH-1:0] buf_wdata [PORTS];

    logic grant_i;
    logic grant_d;

    assign in_addr[0]  = bus.imem_addr;
    assign in_rmask[0] = bus.imem_rmask;
    assign in_wmask[0] = '0;
    assign in_wdata[0] = '0;
    assign in_addr[1]  = bus.dmem_addr;
    assign in_rmask[1] = bus.dmem_rmask;
    assign in_wmask[1] = bus.dmem_wmask;
    assign in_wdata[1] = bus.dmem_wdata;

    // A buffer is released in the cycle its owner's response is returned.
    assign clear[0] = (state_reg == WAIT_I) && bus.mem_resp;
    assign clear[1] = (state_reg == WAIT_D) && bus.mem_resp;

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_port
            logic                  valid_reg;
            logic [ADDR_WIDTH-1:0] addr_reg;
            logic [MASK_WIDTH-1:0] rmask_reg;
            logic [MASK_WIDTH-1:0] wmask_reg;
            logic [DATA_WIDTH-1:0] wdata_reg;

            assign req[gi] = (|in_rmask[gi]) | (|in_wmask[gi]);
            // A new request is taken when the buffer is free or is being
            // released this very cycle. Capture beats clear.
            assign accept[gi] = req[gi] && (!valid_reg || clear[gi]);

            // Pending-buffer capture/release for this port
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    addr_reg  <= '0;
                    rmask_reg <= '0;
                    wmask_reg <= '0;
                    wdata_reg <= '0;
                end else if (accept[gi]) begin
                    valid_reg <= 1'b1;
                    addr_reg  <= in_addr[gi];
                    rmask_reg <= in_rmask[gi];
                    wmask_reg <= in_wmask[gi];
                    wdata_reg <= in_wdata[gi];
                end else if (clear[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign buf_valid[gi] = valid_reg;
            assign buf_addr[gi]  = addr_reg;
            assign buf_rmask[gi] = rmask_reg;
            assign buf_wmask[gi] = wmask_reg;
            assign buf_wdata[gi] = wdata_reg;
        end
    endgenerate

    // Grant only from IDLE. On a tie, serve the port that was not served last.
    assign grant_d = (state_reg == IDLE) && buf_valid[1] && (!buf_valid[0] || !last_grant_d_reg);
    assign grant_i = (state_reg == IDLE) && buf_valid[0] && (!buf_valid[1] || last_grant_d_reg);

    // Transaction sequencer: one issue cycle in IDLE, then wait for mem_resp
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            last_grant_d_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_d) begin
                        state_reg <= WAIT_D;
                    end else if (grant_i) begin
                        state_reg <= WAIT_I;
                    end
                end
                WAIT_I: begin
                    if (bus.mem_resp) begin
                        state_reg        <= IDLE;
                        last_grant_d_reg <= 1'b0;
                    end
                end
                WAIT_D: begin
                    if (bus.mem_resp) begin
                        state_reg        <= IDLE;
                        last_grant_d_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Downstream request: driven from the granted buffer for the IDLE cycle only
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_rmask = '0;
        bus.mem_wmask = '0;
        bus.mem_wdata = '0;
        if (grant_d) begin
            bus.mem_addr  = buf_addr[1];
            bus.mem_rmask = buf_rmask[1];
            bus.mem_wmask = buf_wmask[1];
            bus.mem_wdata = buf_wdata[1];
        end else if (grant_i) begin
            bus.mem_addr  = buf_addr[0];
            bus.mem_rmask = buf_rmask[0];
        end
    end

    // Response routing is combinational. A mem_resp seen in IDLE matches no clear and is dropped.
    assign bus.imem_resp  = clear[0];
    assign bus.dmem_resp  = clear[1];
    assign bus.imem_rdata = bus.mem_rdata;
    assign bus.dmem_rdata = bus.mem_rdata;

`ifdef MEM_ARB_PERF_EN
    logic [2:0]                perf_inc;
    logic [PERF_CNT_WIDTH-1:0] perf_cnt [3];

    assign perf_inc = {buf_valid[0] & buf_valid[1], grant_d, grant_i};

    generate
        for (gi = 0; gi < 3; gi++) begin : g_perf
            logic [PERF_CNT_WIDTH-1:0] cnt_reg;

            // Saturating event counter
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (perf_inc[gi] && !(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + PERF_CNT_WIDTH'(1);
                end
            end

            assign perf_cnt[gi] = cnt_reg;
        end
    endgenerate

    assign perf_imem_grants     = perf_cnt[0];
    assign perf_dmem_grants     = perf_cnt[1];
    assign perf_conflict_cycles = perf_cnt[2];
`else
    // Counter width only matters when the counters exist.
    generate
        if (PERF_CNT_WIDTH < 1) begin : g_perf_width_unused
        end
    endgenerate
`endif

    // Requesters must wait for their response before asking again.
    a_imem_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !(req[0] && buf_valid[0] && !clear[0]));
    a_dmem_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !(req[1] && buf_valid[1] && !clear[1]));
    // A data access is either a load or a store, never both.
    a_dmem_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !((|bus.dmem_rmask) && (|bus.dmem_wmask)));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_imem_grants;
    logic [31:0] perf_dmem_grants;
    logic [31:0] perf_conflict_cycles;
`endif

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PERF_CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_imem_grants     (perf_imem_grants),
        .perf_dmem_grants     (perf_dmem_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.imem_addr  = '0;
        bus.imem_rmask = '0;
        bus.dmem_addr  = '0;
        bus.dmem_rmask = '0;
        bus.dmem_wmask = '0;
        bus.dmem_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_resp   = 1'b0;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (bus.mem_rmask !== 4'h0) begin errors++; $display("FAIL reset_rmask: got %h expected 0", bus.mem_rmask); end
        checks++; if (bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL reset_wmask: got %h expected 0", bus.mem_wmask); end
        checks++; if (bus.imem_resp !== 1'b0) begin errors++; $display("FAIL reset_imem_resp: got %b expected 0", bus.imem_resp); end
        checks++; if (bus.dmem_resp !== 1'b0) begin errors++; $display("FAIL reset_dmem_resp: got %b expected 0", bus.dmem_resp); end
`ifdef MEM_ARB_PERF_EN
        checks++; if (perf_imem_grants !== 0 || perf_dmem_grants !== 0 || perf_conflict_cycles !== 0) begin
            errors++; $display("FAIL reset_perf: got %0d/%0d/%0d expected 0/0/0", perf_imem_grants, perf_dmem_grants, perf_conflict_cycles); end
`endif
        advance();
    endtask

    task automatic test_lone_fetch();
        do_reset();
        // cycle 1: request
        bus.imem_rmask = 4'hF; bus.imem_addr = 32'h6000_0000;
        @(negedge clk);
        checks++; if (bus.mem_rmask !== 4'h0) begin errors++; $display("FAIL fetch_early_issue: got %h expected 0", bus.mem_rmask); end
        advance();
        // cycle 2: issued for this cycle only
        bus.imem_rmask = 4'h0; bus.imem_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (bus.mem_rmask !== 4'hF) begin errors++; $display("FAIL fetch_rmask: got %h expected f", bus.mem_rmask); end
        checks++; if (bus.mem_addr !== 32'h6000_0000) begin errors++; $display("FAIL fetch_addr: got %h expected 60000000", bus.mem_addr); end
        checks++; if (bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL fetch_wmask: got %h expected 0", bus.mem_wmask); end
        // cycles 3,4: waiting
        for (int k = 0; k < 2; k++) begin
            advance();
            @(negedge clk);
            checks++; if (bus.mem_rmask !== 4'h0 || bus.imem_resp !== 1'b0) begin
                errors++; $display("FAIL fetch_wait: rmask %h resp %b expected 0 0", bus.mem_rmask, bus.imem_resp); end
        end
        advance();
        // cycle 5: response
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h0000_0013;
        @(negedge clk);
        checks++; if (bus.imem_resp !== 1'b1) begin errors++; $display("FAIL fetch_resp: got %b expected 1", bus.imem_resp); end
        checks++; if (bus.imem_rdata !== 32'h0000_0013) begin errors++; $display("FAIL fetch_rdata: got %h expected 00000013", bus.imem_rdata); end
        checks++; if (bus.dmem_resp !== 1'b0) begin errors++; $display("FAIL fetch_dmem_resp: got %b expected 0", bus.dmem_resp); end
        $display("txn lone_fetch: addr 60000000 rdata %h", bus.imem_rdata);
        advance();
        bus.mem_resp = 1'b0;
        @(negedge clk);
        checks++; if (bus.imem_resp !== 1'b0) begin errors++; $display("FAIL fetch_resp_pulse: got %b expected 0", bus.imem_resp); end
        advance();
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.imem_rmask = 4'hF; bus.imem_addr = 32'h100;
        bus.dmem_rmask = 4'hF; bus.dmem_addr = 32'h200;
        advance();
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.mem_addr !== 32'h200 || bus.mem_rmask !== 4'hF) begin
            errors++; $display("FAIL simul_first: got addr %h rmask %h expected 200 f", bus.mem_addr, bus.mem_rmask); end
        advance();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'hAAAA_0001;
        @(negedge clk);
        checks++; if (bus.dmem_resp !== 1'b1 || bus.imem_resp !== 1'b0) begin
            errors++; $display("FAIL simul_dresp: got d %b i %b expected 1 0", bus.dmem_resp, bus.imem_resp); end
        checks++; if (bus.mem_rmask !== 4'h0) begin errors++; $display("FAIL simul_no_issue_in_resp: got %h expected 0", bus.mem_rmask); end
        advance();
        bus.mem_resp = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_addr !== 32'h100 || bus.mem_rmask !== 4'hF) begin
            errors++; $display("FAIL simul_second: got addr %h rmask %h expected 100 f", bus.mem_addr, bus.mem_rmask); end
        advance();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'hAAAA_0002;
        @(negedge clk);
        checks++; if (bus.imem_resp !== 1'b1 || bus.imem_rdata !== 32'hAAAA_0002) begin
            errors++; $display("FAIL simul_iresp: got %b %h expected 1 aaaa0002", bus.imem_resp, bus.imem_rdata); end
        $display("txn simultaneous: dmem 200 then imem 100");
        advance();
        clear_inputs();
    endtask

    task automatic test_alternation();
        do_reset();
        bus.imem_rmask = 4'hF; bus.imem_addr = 32'h1000;
        bus.dmem_rmask = 4'hF; bus.dmem_addr = 32'h2000;
        advance();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_addr;
            exp_addr = (k % 2 == 0) ? 32'h2000 : 32'h1000;
            @(negedge clk);
            checks++; if (bus.mem_addr !== exp_addr || bus.mem_rmask !== 4'hF) begin
                errors++; $display("FAIL alt_order_%0d: got addr %h rmask %h expected %h f", k, bus.mem_addr, bus.mem_rmask, exp_addr); end
            $display("txn alternation %0d: addr %h", k, bus.mem_addr);
            advance();
            // respond and let the owner re-request in the same cycle
            bus.mem_resp = 1'b1;
            if (k % 2 == 0) begin bus.dmem_rmask = 4'hF; bus.dmem_addr = 32'h2000; end
            else            begin bus.imem_rmask = 4'hF; bus.imem_addr = 32'h1000; end
            advance();
            clear_inputs();
        end
    endtask

    task automatic test_store();
        do_reset();
        bus.dmem_wmask = 4'b0011; bus.dmem_wdata = 32'hDEAD_BEEF; bus.dmem_addr = 32'h300;
        advance();
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.mem_wmask !== 4'b0011) begin errors++; $display("FAIL store_wmask: got %h expected 3", bus.mem_wmask); end
        checks++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_wdata: got %h expected deadbeef", bus.mem_wdata); end
        checks++; if (bus.mem_rmask !== 4'h0 || bus.mem_addr !== 32'h300) begin
            errors++; $display("FAIL store_rmask_addr: got %h %h expected 0 300", bus.mem_rmask, bus.mem_addr); end
        advance();
        @(negedge clk);
        checks++; if (bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL store_one_cycle: got %h expected 0", bus.mem_wmask); end
        advance();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        checks++; if (bus.dmem_resp !== 1'b1) begin errors++; $display("FAIL store_resp: got %b expected 1", bus.dmem_resp); end
        $display("txn store: addr 300 wmask 3 wdata deadbeef");
        advance();
        clear_inputs();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        bus.dmem_rmask = 4'hF; bus.dmem_addr = 32'h400;
        advance();
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.mem_rmask !== 4'hF || bus.mem_addr !== 32'h400) begin
            errors++; $display("FAIL rstmid_issue: got %h %h expected f 400", bus.mem_rmask, bus.mem_addr); end
        advance();
        bus.imem_rmask = 4'hF; bus.imem_addr = 32'h500;   // pends behind WAIT_D
        advance();
        clear_inputs();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        bus.mem_resp = 1'b1;                              // in-flight response arriving after reset
        @(negedge clk);
        checks++; if (bus.imem_resp !== 1'b0 || bus.dmem_resp !== 1'b0) begin
            errors++; $display("FAIL rstmid_stray_resp: got i %b d %b expected 0 0", bus.imem_resp, bus.dmem_resp); end
        advance();
        bus.mem_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus.mem_rmask !== 4'h0 || bus.mem_wmask !== 4'h0) begin
                errors++; $display("FAIL rstmid_quiet_%0d: got %h %h expected 0 0", k, bus.mem_rmask, bus.mem_wmask); end
            advance();
        end
        bus.imem_rmask = 4'hF; bus.imem_addr = 32'h700;
        advance();
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.mem_rmask !== 4'hF || bus.mem_addr !== 32'h700) begin
            errors++; $display("FAIL rstmid_idle: got %h %h expected f 700", bus.mem_rmask, bus.mem_addr); end
        advance();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_resp !== 1'b1) begin errors++; $display("FAIL rstmid_after_resp: got %b expected 1", bus.imem_resp); end
        $display("txn reset_mid_op: in-flight dropped, fetch 700 served");
        advance();
        clear_inputs();
    endtask

    task automatic test_protocol_corner();
        do_reset();
        bus.dmem_rmask = 4'hF; bus.dmem_addr = 32'h800;
        advance();
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.mem_addr !== 32'h800) begin errors++; $display("FAIL corner_first: got %h expected 800", bus.mem_addr); end
        advance();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h55;
        bus.dmem_rmask = 4'h3; bus.dmem_addr = 32'h900;   // new request with own response
        @(negedge clk);
        checks++; if (bus.dmem_resp !== 1'b1 || bus.dmem_rdata !== 32'h55) begin
            errors++; $display("FAIL corner_resp: got %b %h expected 1 55", bus.dmem_resp, bus.dmem_rdata); end
        advance();
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.mem_rmask !== 4'h3 || bus.mem_addr !== 32'h900) begin
            errors++; $display("FAIL corner_second: got %h %h expected 3 900", bus.mem_rmask, bus.mem_addr); end
        advance();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        checks++; if (bus.dmem_resp !== 1'b1) begin errors++; $display("FAIL corner_second_resp: got %b expected 1", bus.dmem_resp); end
        $display("txn protocol_corner: 800 then 900");
        advance();
        clear_inputs();
    endtask

    // Transaction-level model: each requester has an outstanding request
    // (waiting) that becomes eligible the cycle after it is made (queued).
    // The arbiter issues whenever nothing is outstanding and something is
    // queued, alternating on ties. Memory responds 1..4 cycles after issue.
    task automatic test_random(int ncycles);
        bit i_wait = 0, d_wait = 0, i_q = 0, d_q = 0;
        bit last_d = 0, busy = 0, own_d = 0;
        int delay = 0, ig = 0, dg = 0, conf = 0, ntx = 0;
        logic [31:0] ia = 0, da = 0, dwd = 0;
        logic [3:0]  ir = 0, dr = 0, dw = 0;
        do_reset();
        for (int c = 0; c < ncycles; c++) begin
            bit resp_now, ri, rd, issue, exp_issue, exp_d, bi, bd;
            logic [31:0] rdat;
            bi = i_wait; bd = d_wait;
            resp_now = busy && (delay == 0);
            rdat = $urandom;
            bus.mem_resp  = resp_now;
            bus.mem_rdata = rdat;
            ri = (!i_wait || (resp_now && !own_d)) && ($urandom_range(0, 2) == 0);
            rd = (!d_wait || (resp_now && own_d)) && ($urandom_range(0, 2) == 0);
            bus.imem_addr  = $urandom;
            bus.imem_rmask = ri ? 4'($urandom_range(1, 15)) : 4'h0;
            bus.dmem_addr  = $urandom;
            bus.dmem_wdata = $urandom;
            bus.dmem_rmask = 4'h0;
            bus.dmem_wmask = 4'h0;
            if (rd) begin
                if ($urandom_range(0, 1) == 0) bus.dmem_rmask = 4'($urandom_range(1, 15));
                else                           bus.dmem_wmask = 4'($urandom_range(1, 15));
            end
            @(negedge clk);
            issue = (|bus.mem_rmask) || (|bus.mem_wmask);
            exp_issue = !busy && (i_q || d_q);
            checks++; if (issue !== exp_issue) begin
                errors++; $display("FAIL rnd_issue cycle %0d: got %b expected %b", c, issue, exp_issue); end
            if (exp_issue) begin
                exp_d = (i_q && d_q) ? !last_d : d_q;
                if (exp_d) begin
                    checks++; if (bus.mem_addr !== da || bus.mem_rmask !== dr || bus.mem_wmask !== dw || (dw != 0 && bus.mem_wdata !== dwd)) begin
                        errors++; $display("FAIL rnd_dmem_txn cycle %0d: got %h %h %h %h expected %h %h %h %h", c, bus.mem_addr, bus.mem_rmask, bus.mem_wmask, bus.mem_wdata, da, dr, dw, dwd); end
                    dg++; d_q = 0;
                end else begin
                    checks++; if (bus.mem_addr !== ia || bus.mem_rmask !== ir || bus.mem_wmask !== 4'h0) begin
                        errors++; $display("FAIL rnd_imem_txn cycle %0d: got %h %h %h expected %h %h 0", c, bus.mem_addr, bus.mem_rmask, bus.mem_wmask, ia, ir); end
                    ig++; i_q = 0;
                end
                ntx++;
                $display("txn rnd %0d: cycle %0d port %s addr %h", ntx, c, exp_d ? "D" : "I", exp_d ? da : ia);
                busy = 1; own_d = exp_d; delay = $urandom_range(0, 3);
            end else if (busy && !resp_now) begin
                delay--;
            end
            checks++; if (bus.imem_resp !== (resp_now && !own_d) || bus.dmem_resp !== (resp_now && own_d)) begin
                errors++; $display("FAIL rnd_resp cycle %0d: got i %b d %b expected i %b d %b", c, bus.imem_resp, bus.dmem_resp, resp_now && !own_d, resp_now && own_d); end
            if (resp_now) begin
                checks++; if ((own_d ? bus.dmem_rdata : bus.imem_rdata) !== rdat) begin
                    errors++; $display("FAIL rnd_rdata cycle %0d: got %h expected %h", c, own_d ? bus.dmem_rdata : bus.imem_rdata, rdat); end
                busy = 0; last_d = own_d;
                if (own_d) d_wait = 0; else i_wait = 0;
            end
            if (bi && bd) conf++;
            if (ri) begin i_wait = 1; i_q = 1; ia = bus.imem_addr; ir = bus.imem_rmask; end
            if (rd) begin d_wait = 1; d_q = 1; da = bus.dmem_addr; dr = bus.dmem_rmask; dw = bus.dmem_wmask; dwd = bus.dmem_wdata; end
            advance();
        end
        clear_inputs();
        checks++; if (ntx < 10) begin errors++; $display("FAIL rnd_activity: got %0d transactions expected at least 10", ntx); end
`ifdef MEM_ARB_PERF_EN
        checks++; if (perf_imem_grants !== ig || perf_dmem_grants !== dg || perf_conflict_cycles !== conf) begin
            errors++; $display("FAIL rnd_perf: got %0d/%0d/%0d expected %0d/%0d/%0d", perf_imem_grants, perf_dmem_grants, perf_conflict_cycles, ig, dg, conf); end
`endif
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_alternation();
        test_store();
        test_reset_mid_op();
        test_protocol_corner();
        test_random(2000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
